// File: rtl/store_commit_arbiter_pkg.sv
// Shared widths, NULL reorder-buffer index and state encodings for the store commit arbiter.
package store_commit_arbiter_pkg;

  localparam int DEF_STORER_NUM = 2;
  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_RB_INDEX   = 4;

  // Reorder-buffer index reserved to mean "no instruction"; it never commits a held store.
  localparam int NULL_RBIDX = 0;

  typedef enum logic [1:0] {
    SLOT_EMPTY       = 2'd0,
    SLOT_WAIT_COMMIT = 2'd1,
    SLOT_READY       = 2'd2,
    SLOT_WRITING     = 2'd3
  } slot_state_e;

  typedef enum logic {
    PORT_IDLE  = 1'b0,
    PORT_WRITE = 1'b1
  } port_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/store_hold_slot.sv
// One holding slot: latches a completed store and tracks it from capture through commit
// to the end of its memory write.
module store_hold_slot
  import store_commit_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int RB_INDEX  = DEF_RB_INDEX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [WORD_SIZE-1:0] cap_addr,
  input  logic [WORD_SIZE-1:0] cap_data,
  input  logic [RB_INDEX-1:0]  cap_rbidx,
  input  logic                 commit_valid,
  input  logic [RB_INDEX-1:0]  commit_rbidx,
  input  logic                 flush,
  input  logic                 grant,
  input  logic                 write_done,
  output logic                 ready,
  output logic                 full,
  output logic                 overflow_hit,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] data,
  output logic [RB_INDEX-1:0]  rbidx
);

  localparam logic [RB_INDEX-1:0] NULL_IDX = RB_INDEX'(NULL_RBIDX);

  slot_state_e          state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, data_q;
  logic [RB_INDEX-1:0]  rbidx_q;
  logic                 held_hit, capture_hit;

  assign held_hit    = commit_valid && (commit_rbidx == rbidx_q)   && (rbidx_q   != NULL_IDX);
  assign capture_hit = commit_valid && (commit_rbidx == cap_rbidx) && (cap_rbidx != NULL_IDX);

  // A same-cycle commit overrides flush; a capture arriving with flush is discarded unless committed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (capture) begin
          if (capture_hit)  state_d = SLOT_READY;
          else if (!flush)  state_d = SLOT_WAIT_COMMIT;
        end
      end
      SLOT_WAIT_COMMIT: begin
        if (held_hit)       state_d = SLOT_READY;
        else if (flush)     state_d = SLOT_EMPTY;
      end
      SLOT_READY: begin
        if (grant)          state_d = SLOT_WRITING;
      end
      SLOT_WRITING: begin
        if (write_done)     state_d = SLOT_EMPTY;
      end
      default:              state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      rbidx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SLOT_EMPTY && capture) begin
        addr_q  <= cap_addr;
        data_q  <= cap_data;
        rbidx_q <= cap_rbidx;
      end
    end
  end

  assign ready        = (state_q == SLOT_READY);
  assign full         = (state_q != SLOT_EMPTY);
  assign overflow_hit = capture && (state_q != SLOT_EMPTY);
  assign addr         = addr_q;
  assign data         = data_q;
  assign rbidx        = rbidx_q;

endmodule

// File: rtl/store_commit_arbiter.sv
// Holds completed stores until the ROB commits them, then round-robin arbitrates the
// committed ones onto the single data-memory write port.
module store_commit_arbiter
  import store_commit_arbiter_pkg::*;
#(
  parameter int STORER_NUM = DEF_STORER_NUM,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int RB_INDEX   = DEF_RB_INDEX
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [STORER_NUM-1:0]           st_valid,
  input  logic [STORER_NUM*WORD_SIZE-1:0] st_addr,
  input  logic [STORER_NUM*WORD_SIZE-1:0] st_data,
  input  logic [STORER_NUM*RB_INDEX-1:0]  st_rbidx,
  input  logic                            commit_valid,
  input  logic [RB_INDEX-1:0]             commit_rbidx,
  input  logic                            flush,
  output logic                            mem_we,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic                            mem_ack,
  output logic                            st_done,
  output logic [RB_INDEX-1:0]             st_done_idx,
  output logic [STORER_NUM-1:0]           slot_full,
  output logic                            overflow
);

  localparam int IDX_W = (STORER_NUM > 1) ? $clog2(STORER_NUM) : 1;

  logic [STORER_NUM-1:0] slot_ready, slot_ovf;
  logic [WORD_SIZE-1:0]  slot_addr  [STORER_NUM];
  logic [WORD_SIZE-1:0]  slot_data  [STORER_NUM];
  logic [RB_INDEX-1:0]   slot_rbidx [STORER_NUM];

  port_state_e          port_q, port_d;
  logic [IDX_W-1:0]     rr_q, gidx_q, pick;
  logic                 any_ready, grant_fire, write_done;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;
  logic                 done_q, ovf_q;
  logic [RB_INDEX-1:0]  done_idx_q;

  assign write_done = (port_q == PORT_WRITE) && mem_ack;
  assign grant_fire = (port_q == PORT_IDLE) && any_ready;

  for (genvar i = 0; i < STORER_NUM; i++) begin : g_slot
    store_hold_slot #(
      .WORD_SIZE (WORD_SIZE),
      .RB_INDEX  (RB_INDEX)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .capture      (st_valid[i]),
      .cap_addr     (st_addr[i*WORD_SIZE +: WORD_SIZE]),
      .cap_data     (st_data[i*WORD_SIZE +: WORD_SIZE]),
      .cap_rbidx    (st_rbidx[i*RB_INDEX +: RB_INDEX]),
      .commit_valid (commit_valid),
      .commit_rbidx (commit_rbidx),
      .flush        (flush),
      .grant        (grant_fire && (pick == IDX_W'(i))),
      .write_done   (write_done && (gidx_q == IDX_W'(i))),
      .ready        (slot_ready[i]),
      .full         (slot_full[i]),
      .overflow_hit (slot_ovf[i]),
      .addr         (slot_addr[i]),
      .data         (slot_data[i]),
      .rbidx        (slot_rbidx[i])
    );
  end

  // Scan from the highest offset down so the first READY slot at or after rr_q wins.
  always_comb begin
    int idx;
    any_ready = 1'b0;
    pick      = '0;
    idx       = 0;
    for (int k = STORER_NUM - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= STORER_NUM) idx = idx - STORER_NUM;
      if (slot_ready[IDX_W'(idx)]) begin
        any_ready = 1'b1;
        pick      = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    port_d = port_q;
    case (port_q)
      PORT_IDLE:  if (any_ready) port_d = PORT_WRITE;
      PORT_WRITE: if (mem_ack)   port_d = PORT_IDLE;
      default:                   port_d = PORT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q     <= PORT_IDLE;
      rr_q       <= '0;
      gidx_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      done_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      port_q <= port_d;
      done_q <= write_done;
      ovf_q  <= ovf_q | (|slot_ovf);
      if (grant_fire) begin
        gidx_q  <= pick;
        rr_q    <= IDX_W'(rr_next(int'(pick), STORER_NUM));
        addr_q  <= slot_addr[pick];
        wdata_q <= slot_data[pick];
      end
      if (write_done) done_idx_q <= slot_rbidx[gidx_q];
    end
  end

  assign mem_we      = (port_q == PORT_WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign st_done     = done_q;
  assign st_done_idx = done_idx_q;
  assign overflow    = ovf_q;

endmodule
